// File: rtl/jt2148_pkg.sv
// Shared receiver FSM states and oversampling constants for the jt2148 MIDI UART.
package jt2148_pkg;

   localparam int OVS = 16;
   localparam int MID = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

endpackage

// File: rtl/jt2148_fifo.sv
// Generic FIFO with combinational head; a push into a full queue is dropped (ovr_o pulses)
// unless a pop lands in the same cycle, in which case both take effect.
module jt2148_fifo
   import jt2148_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_vld_i,
   input  logic [DW-1:0] wr_dat_i,
   input  logic          rd_i,
   output logic [DW-1:0] rd_dat_o,
   output logic          rd_vld_o,
   output logic          ovr_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full, do_rd, do_wr;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH-1)) ? '0 : p + 1'b1;
   endfunction

   assign full     = (cnt_q == (AW+1)'(DEPTH));
   assign do_rd    = rd_i && (cnt_q != '0);
   assign do_wr    = wr_vld_i && (!full || do_rd);
   assign ovr_o    = wr_vld_i && full && !do_rd;
   assign rd_vld_o = (cnt_q != '0);
   assign rd_dat_o = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (do_wr) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_rd) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({do_wr, do_rd})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // When full, wr_ptr equals rd_ptr: a coincident pop frees exactly the slot being written.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         if (do_wr) mem_q[wr_ptr_q] <= wr_dat_i;
      end
   end

endmodule

// File: rtl/jt2148_midi_rx.sv
// MIDI 8N1 receiver, 16x oversampled, feeding a receive queue; byte visible the clk after the stop sample.
// Queue is 4 deep with JT2148_RXFIFO_EN defined, otherwise a single holding register.
module jt2148_midi_rx
   import jt2148_pkg::*;
#(
   parameter int DIV = 8,
   parameter int DW  = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          midi_rx,
   input  logic          rd,
   input  logic          clr_err,
   input  logic          irq_en,
   output logic [DW-1:0] rx_data,
   output logic          rx_rdy,
   output logic          rx_ovr,
   output logic          rx_ferr,
   output logic          irq_n
);

`ifdef JT2148_RXFIFO_EN
   localparam int QDEPTH = 4;
`else
   localparam int QDEPTH = 1;
`endif
   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (DW > 1) ? $clog2(DW) : 1;

   logic          rx_s1_q, rx_s2_q, rx_prev_q;
   logic [PW-1:0] presc_q;
   logic          tick;
   rx_state_e     state_q, state_d;
   logic [3:0]    tick_cnt_q, tick_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic [DW-1:0] shift_q, shift_d;
   logic          push, ferr_set, ovr_set;
   logic          ovr_q, ferr_q;

   assign tick = (presc_q == PW'(DIV-1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         presc_q    <= '0;
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         rx_s1_q    <= midi_rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         presc_q    <= tick ? '0 : presc_q + 1'b1;
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         // A set wins over a coincident clear.
         ovr_q      <= ovr_set  | (ovr_q  & ~clr_err);
         ferr_q     <= ferr_set | (ferr_q & ~clr_err);
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      push       = 1'b0;
      ferr_set   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (rx_prev_q && !rx_s2_q) begin
               tick_cnt_d = '0;
               state_d    = ST_START;
            end
         end
         ST_START: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               if (tick_cnt_q == 4'(MID-1)) begin
                  tick_cnt_d = '0;
                  bit_cnt_d  = '0;
                  state_d    = rx_s2_q ? ST_IDLE : ST_DATA;
               end
            end
         end
         // The 4-bit tick counter wraps at OVS, so each bit period restarts it implicitly.
         ST_DATA: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               if (tick_cnt_q == 4'(OVS-1)) begin
                  shift_d   = {rx_s2_q, shift_q[DW-1:1]};
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  if (bit_cnt_q == BW'(DW-1)) state_d = ST_STOP;
               end
            end
         end
         ST_STOP: begin
            if (tick) begin
               tick_cnt_d = tick_cnt_q + 1'b1;
               if (tick_cnt_q == 4'(OVS-1)) begin
                  if (rx_s2_q) begin
                     push    = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     ferr_set = 1'b1;
                     state_d  = ST_BREAK;
                  end
               end
            end
         end
         ST_BREAK: begin
            if (rx_s2_q) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   jt2148_fifo #(
      .DEPTH (QDEPTH),
      .DW    (DW)
   ) u_rxq (
      .clk      (clk),
      .rst      (rst),
      .wr_vld_i (push),
      .wr_dat_i (shift_q),
      .rd_i     (rd),
      .rd_dat_o (rx_data),
      .rd_vld_o (rx_rdy),
      .ovr_o    (ovr_set)
   );

   assign rx_ovr  = ovr_q;
   assign rx_ferr = ferr_q;
   assign irq_n   = ~(irq_en & (rx_rdy | ovr_q | ferr_q));

endmodule

// File: tb/tb_jt2148_midi_rx.sv
// Randomized bench for jt2148_midi_rx against a byte-queue reference model.
module tb_jt2148_midi_rx;

`ifdef JT2148_RXFIFO_EN
   localparam int QD = 4;
`else
   localparam int QD = 1;
`endif
   localparam int BIT = 128;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       midi_rx = 1'b1;
   logic       rd = 1'b0;
   logic       clr_err = 1'b0;
   logic       irq_en = 1'b0;
   logic [7:0] rx_data;
   logic       rx_rdy, rx_ovr, rx_ferr, irq_n;

   int         cyc;
   int         nchk = 0;
   int         nerr = 0;
   logic [7:0] mq[$];
   bit         m_ovr = 1'b0;
   bit         m_ferr = 1'b0;

   jt2148_midi_rx #(.DIV(8), .DW(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .midi_rx (midi_rx),
      .rd      (rd),
      .clr_err (clr_err),
      .irq_en  (irq_en),
      .rx_data (rx_data),
      .rx_rdy  (rx_rdy),
      .rx_ovr  (rx_ovr),
      .rx_ferr (rx_ferr),
      .irq_n   (irq_n)
   );

   always #5 clk = ~clk;

   // Clock edges since reset release; prescaler ticks fall on edges where cyc % 8 == 0.
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_state(input string tag);
      bit any;
      any = (mq.size() != 0);
      chk({tag, ".rdy"}, 32'(rx_rdy), 32'(any));
      if (any) chk({tag, ".data"}, 32'(rx_data), 32'(mq[0]));
      chk({tag, ".ovr"}, 32'(rx_ovr), 32'(m_ovr));
      chk({tag, ".ferr"}, 32'(rx_ferr), 32'(m_ferr));
      chk({tag, ".irq_n"}, 32'(irq_n), 32'(!(irq_en && (any || m_ovr || m_ferr))));
   endtask

   task automatic pop(input string tag);
      @(negedge clk);
      if (mq.size() != 0) chk({tag, ".pop"}, 32'(rx_data), 32'(mq[0]));
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      if (mq.size() != 0) void'(mq.pop_front());
      check_state(tag);
   endtask

   task automatic clr(input string tag);
      @(negedge clk);
      clr_err = 1'b1;
      @(negedge clk);
      clr_err = 1'b0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      check_state(tag);
   endtask

   // Start the line change r clocks after a tick edge so the stop-bit sample edge is known.
   task automatic align(output int r);
      r = int'($urandom_range(0, 4));
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         if (cyc % 8 == r) break;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_hi, input bit rd_push,
                             input bit clr_push, input int rst_at);
      int  r, t_push, total;
      bit  was_empty;
      align(r);
      // Start detected before the next tick; stop sampled 8 + 9*16 ticks later.
      t_push    = BIT * 9 + 64 - 1 - r;
      total     = (stop_hi ? 10 : 13) * BIT + 32;
      was_empty = (mq.size() == 0);
      for (int t = 0; t < total; t++) begin
         int s;
         s = t / BIT;
         if (rst_at >= 0 && t == rst_at) begin
            rst     = 1'b1;
            midi_rx = 1'b1;
            rd      = 1'b0;
            clr_err = 1'b0;
            mq.delete();
            m_ovr   = 1'b0;
            m_ferr  = 1'b0;
            repeat (3) @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (s == 0)                   midi_rx = 1'b0;
         else if (s <= 8)              midi_rx = b[3'(s - 1)];
         else if (s == 9)              midi_rx = stop_hi;
         else if (!stop_hi && s <= 11) midi_rx = 1'b0;
         else                          midi_rx = 1'b1;
         rd      = 1'b0;
         clr_err = 1'b0;
         if (t == t_push) begin
            if (was_empty && stop_hi) chk("latency.before", 32'(rx_rdy), 32'd0);
            if (rd_push && mq.size() != 0) chk("push_rd.data", 32'(rx_data), 32'(mq[0]));
            rd      = rd_push;
            clr_err = clr_push;
         end
         if (t == t_push + 1 && was_empty && stop_hi) chk("latency.after", 32'(rx_rdy), 32'd1);
         @(negedge clk);
      end
      rd      = 1'b0;
      clr_err = 1'b0;
      if (rd_push && mq.size() != 0) void'(mq.pop_front());
      if (clr_push) begin
         m_ovr  = 1'b0;
         m_ferr = 1'b0;
      end
      if (!stop_hi)             m_ferr = 1'b1;
      else if (mq.size() < QD)  mq.push_back(b);
      else                      m_ovr = 1'b1;
   endtask

   task automatic glitch(input int width);
      int r;
      align(r);
      midi_rx = 1'b0;
      repeat (width) @(negedge clk);
      midi_rx = 1'b1;
      repeat (200) @(negedge clk);
   endtask

   initial begin
      logic [7:0] rb;
      bit         rs, rr, rc;
      irq_en = 1'b1;
      repeat (4) @(negedge clk);
      check_state("reset");
      chk("reset.data", 32'(rx_data), 32'd0);
      rst = 1'b0;
      repeat (20) @(negedge clk);

      send_frame(8'h90, 1'b1, 1'b0, 1'b0, -1);
      check_state("b90");
      pop("b90.rd");
      pop("rd_empty");

      glitch(24);
      check_state("glitch");

      send_frame(8'h45, 1'b0, 1'b0, 1'b0, -1);
      check_state("ferr");
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, -1);
      check_state("after_ferr");
      pop("b12.rd");
      clr("clr1");

      for (int i = 1; i <= QD + 1; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, -1);
      check_state("overrun");
      for (int i = 0; i < QD; i++) pop("ovr.rd");
      clr("clr2");

      for (int i = 0; i < QD; i++) send_frame(8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'hB5, 1'b1, 1'b1, 1'b0, -1);
      check_state("full_rd_push");
      for (int i = 0; i < QD; i++) pop("full_rd.rd");

      send_frame(8'h33, 1'b0, 1'b0, 1'b1, -1);
      check_state("clr_vs_ferr");
      clr("clr3");

      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
      send_frame(8'hF8, 1'b1, 1'b0, 1'b0, BIT * 5 + 60);
      check_state("rst_mid");
      chk("rst_mid.data", 32'(rx_data), 32'd0);
      repeat (20) @(negedge clk);
      send_frame(8'hFE, 1'b1, 1'b0, 1'b0, -1);
      check_state("bFE");
      pop("bFE.rd");

      for (int i = 0; i < 12; i++) begin
         rb     = 8'($urandom);
         rs     = ($urandom % 6) != 0;
         rr     = ($urandom % 4) == 0;
         rc     = ($urandom % 8) == 0;
         irq_en = 1'($urandom);
         send_frame(rb, rs, rr, rc, -1);
         check_state("rand");
         repeat (int'($urandom_range(0, 2))) pop("rand.rd");
         if (($urandom % 5) == 0) clr("rand.clr");
      end
      for (int i = 0; i < QD; i++) pop("drain");

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
